// File: rtl/regfile_sweep_pkg.sv
// Shared types, default parameters and the reset-pattern helper for regfile_sweep.
package regfile_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_e;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_TICK_DIV = 781250;

    // Upper half of the entry holds the index replicated and truncated; lower half is zero.
    // Result is 64 bits wide; callers keep the low data_w bits.
    function automatic logic [63:0] init_entry(input int data_w, input int addr_w, input int idx);
        logic [63:0] v;
        int          half;
        int          bitv;
        v    = '0;
        half = data_w / 2;
        for (int b = 0; b < half; b++) begin
            bitv = (idx >> (b % addr_w)) & 1;
            v    = v | (64'(bitv) << (half + b));
        end
        return v;
    endfunction

endpackage

// File: rtl/regfile_sweep_if.sv
// Host-side bus of regfile_sweep: two read ports, one write port, sweep control/status.
// Valid/ready note: there is no backpressure; wr_en is a single-cycle strobe that is
// always accepted, and read data is combinational from the current address.
interface regfile_sweep_if
    import regfile_sweep_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              sweep_en;
    logic              sweep_busy;
    logic [ADDR_W-1:0] sweep_idx;
    logic              sweep_done;
    state_e            dbg_state;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, sweep_en,
        input  rd_data_a, rd_data_b, sweep_busy, sweep_idx, sweep_done, dbg_state
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, sweep_en,
        output rd_data_a, rd_data_b, sweep_busy, sweep_idx, sweep_done, dbg_state
    );

endinterface

// File: rtl/regfile_sweep_tick_gen.sv
// Free-running prescaler: tick is high for one cycle out of every TICK_DIV.
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/regfile_sweep.sv
// Register file with two async read ports, one write port shared between the host and
// an internal sweep engine that adds STEP to each entry in turn on every tick.
module regfile_sweep
    import regfile_sweep_pkg::*;
#(
    parameter int              DATA_W   = DEF_DATA_W,
    parameter int              ADDR_W   = DEF_ADDR_W,
    parameter int              TICK_DIV = DEF_TICK_DIV,
    parameter logic [DATA_W-1:0] STEP   = DATA_W'(1)
) (
    input logic            clk,
    input logic            rst,
    regfile_sweep_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    state_e            state;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] hold;
    logic              stale;
    logic              done;
    logic              tick;

    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              sweep_wr;
    logic              wr_hit_idx;
    logic              wr_stall;

    function automatic logic [DATA_W-1:0] reset_val(input int i);
        logic [63:0] v;
        v = init_entry(DATA_W, ADDR_W, i);
        return v[DATA_W-1:0];
    endfunction

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Host writes own the port; the sweep only writes in WR when the host is quiet
    // and no host write hit this entry between read and write.
    always_comb begin
        wr_hit_idx = bus.wr_en && (bus.wr_addr == idx);
        wr_stall   = bus.wr_en && !wr_hit_idx;
        sweep_wr   = (state == WR) && !bus.wr_en && !stale;
        we         = bus.wr_en || sweep_wr;
        wa         = bus.wr_en ? bus.wr_addr : idx;
        wd         = bus.wr_en ? bus.wr_data : hold;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= reset_val(i);
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            hold  <= '0;
            stale <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && bus.sweep_en) begin
                        state <= RD;
                    end
                end
                RD: begin
                    hold  <= mem[idx] + STEP;
                    stale <= wr_hit_idx;
                    state <= WR;
                end
                WR: begin
                    // A host write elsewhere holds us here; otherwise the step retires.
                    if (!wr_stall) begin
                        idx   <= idx + ADDR_W'(1);
                        done  <= &idx;
                        stale <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_data_a  = mem[bus.rd_addr_a];
    assign bus.rd_data_b  = mem[bus.rd_addr_b];
    assign bus.sweep_busy = (state != IDLE);
    assign bus.sweep_idx  = idx;
    assign bus.sweep_done = done;
    assign bus.dbg_state  = state;

endmodule

// File: tb/tb_regfile_sweep.sv
// Directed bench for regfile_sweep with a 4-cycle tick and the 16x16 configuration.
module tb_regfile_sweep;
    import regfile_sweep_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    regfile_sweep_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    regfile_sweep #(
        .DATA_W   (16),
        .ADDR_W   (4),
        .TICK_DIV (4),
        .STEP     (16'd1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int i);
        logic [3:0] n;
        n = 4'(i);
        return {n, n, 8'h00};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic rd_a(input logic [3:0] a, output logic [15:0] v);
        bus.rd_addr_a = a;
        #1;
        v = bus.rd_data_a;
    endtask

    task automatic check_entry(input string tag, input int i, input logic [15:0] exp);
        logic [15:0] v;
        rd_a(4'(i), v);
        check(tag, 32'(v), 32'(exp));
    endtask

    // One sweep step. ph: 0 none, 1 host write during RD, 2 host write during WR.
    task automatic sweep_step(input int ph, input logic [3:0] a, input logic [15:0] d,
                              output int nbusy, output logic done_o);
        int guard;
        guard = 0;
        nbusy = 0;
        bus.sweep_en = 1'b1;
        while (!bus.sweep_busy && guard < 20) begin
            cyc();
            guard++;
        end
        check("busy_rise", 32'(bus.sweep_busy), 32'd1);
        bus.sweep_en = 1'b0;
        while (bus.sweep_busy && guard < 40) begin
            bus.wr_en   = (ph == 1 && nbusy == 0) || (ph == 2 && nbusy == 1);
            bus.wr_addr = a;
            bus.wr_data = d;
            nbusy++;
            cyc();
            guard++;
        end
        bus.wr_en = 1'b0;
        done_o    = bus.sweep_done;
    endtask

    // driver + scoreboard
    initial begin
        int          nb;
        logic        dn;
        int          pulses;
        logic [15:0] v;

        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.sweep_en  = 1'b0;
        cyc();
        cyc();
        check("rst_busy", 32'(bus.sweep_busy), 32'd0);
        check("rst_idx", 32'(bus.sweep_idx), 32'd0);
        check("rst_done", 32'(bus.sweep_done), 32'd0);
        rst = 1'b0;
        cyc();
        for (int i = 0; i < 16; i++) check_entry("rst_entry", i, pat(i));

        // host write: old value in write cycle, new value after the edge
        cyc();
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 4'd3;
        bus.wr_data   = 16'hBEEF;
        bus.rd_addr_b = 4'd3;
        #1;
        check("wr_old", 32'(bus.rd_data_b), 32'h3300);
        cyc();
        bus.wr_en = 1'b0;
        check("wr_new", 32'(bus.rd_data_b), 32'hBEEF);

        // single sweep step on entry 0
        cyc();
        sweep_step(0, 4'd0, 16'h0, nb, dn);
        check("step_busy_cycles", 32'(nb), 32'd2);
        check("step_idx", 32'(bus.sweep_idx), 32'd1);
        check("step_done", 32'(dn), 32'd0);
        check_entry("step_entry0", 0, 16'h0001);
        check_entry("step_entry3", 3, 16'hBEEF);

        // wrap: FFFF + 1 -> 0000, neighbours untouched
        do_reset();
        check("rst2_idx", 32'(bus.sweep_idx), 32'd0);
        check_entry("rst2_entry3", 3, 16'h3300);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd0;
        bus.wr_data = 16'hFFFF;
        cyc();
        bus.wr_en = 1'b0;
        sweep_step(0, 4'd0, 16'h0, nb, dn);
        check_entry("wrap_entry0", 0, 16'h0000);
        check_entry("wrap_entry1", 1, 16'h1100);
        check_entry("wrap_entry15", 15, 16'hFF00);
        check("wrap_idx", 32'(bus.sweep_idx), 32'd1);
        check("wrap_done", 32'(dn), 32'd0);

        // host write to the swept entry during RD wins, step still advances
        cyc();
        sweep_step(1, 4'd1, 16'h1234, nb, dn);
        check("stale_busy_cycles", 32'(nb), 32'd2);
        check_entry("stale_entry1", 1, 16'h1234);
        check("stale_idx", 32'(bus.sweep_idx), 32'd2);

        // host write elsewhere during WR stalls one cycle
        cyc();
        sweep_step(2, 4'd7, 16'h7777, nb, dn);
        check("stall_busy_cycles", 32'(nb), 32'd3);
        check_entry("stall_entry2", 2, 16'h2201);
        check_entry("stall_entry7", 7, 16'h7777);
        check("stall_idx", 32'(bus.sweep_idx), 32'd3);

        // full pass of 16 steps
        do_reset();
        pulses = 0;
        for (int s = 0; s < 16; s++) begin
            sweep_step(0, 4'd0, 16'h0, nb, dn);
            if (dn) pulses++;
            if (s == 15) check("pass_done_last", 32'(dn), 32'd1);
        end
        check("pass_done_pulses", 32'(pulses), 32'd1);
        check("pass_idx", 32'(bus.sweep_idx), 32'd0);
        cyc();
        check("pass_done_clear", 32'(bus.sweep_done), 32'd0);
        for (int i = 0; i < 16; i++) check_entry("pass_entry", i, pat(i) + 16'd1);

        // reset asserted in the WR cycle of the step on entry 5
        do_reset();
        for (int s = 0; s < 5; s++) sweep_step(0, 4'd0, 16'h0, nb, dn);
        check("mid_idx", 32'(bus.sweep_idx), 32'd5);
        bus.sweep_en = 1'b1;
        for (int g = 0; g < 20 && !bus.sweep_busy; g++) cyc();
        bus.sweep_en = 1'b0;
        cyc();
        check("mid_state_wr", 32'(bus.dbg_state), 32'(WR));
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) cyc();
        check("mid_busy", 32'(bus.sweep_busy), 32'd0);
        check("mid_idx_rst", 32'(bus.sweep_idx), 32'd0);
        for (int i = 0; i < 16; i++) check_entry("mid_entry", i, pat(i));
        rd_a(4'd5, v);
        check("mid_entry5", 32'(v), 32'h5500);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_sweep.md
Name: regfile_sweep

Overview:
- Parametrised register file: two asynchronous read ports and one synchronous write port.
- Built-in sweep engine walks every entry on a divided tick and read-modify-writes each entry as entry+STEP.
- Successor to the fixed 16x16 file plus external incrementer: the sweep logic moves inside, and external writes get priority.
- Feeds the 4-digit display path: read port A goes to display, port B is free for host/debug.

Parameters:
- DATA_W, 16, entry width in bits (even, >=8).
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.
- TICK_DIV, 781250, clk cycles per sweep tick (>=2).
- STEP, 1, value added per sweep RMW (width DATA_W).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_data_a  out  DATA_W  file[rd_addr_a], combinational.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_b  out  DATA_W  file[rd_addr_b], combinational.
- wr_en  in  1  external write strobe.
- wr_addr  in  ADDR_W  external write address.
- wr_data  in  DATA_W  external write data.
- sweep_en  in  1  level; enables sweep engine.
- sweep_busy  out  1  high while state != IDLE.
- sweep_idx  out  ADDR_W  entry currently or next targeted by the sweep.
- sweep_done  out  1  one-cycle pulse when a full pass completes.

Behaviour:
- Reset (async, rst high):
  - Entry i: lower DATA_W/2 bits = 0; upper DATA_W/2 bits = i replicated and truncated to DATA_W/2 (16-bit, ADDR_W=4: entry 5 = 16'h5500).
  - state=IDLE, sweep_idx=0, hold=0, tick counter=0, sweep_busy=0, sweep_done=0.
  - Reset mid-RMW discards the hold register; no partial write occurs.
- Reads:
  - Asynchronous, no bypass.
  - A write at edge E is visible on rd_data_* after E.
  - Same-address read in the write cycle returns the old value.
- Tick:
  - Counter runs 0..TICK_DIV-1 continuously, independent of sweep_en.
  - tick=1 for the one cycle where counter==TICK_DIV-1.
- FSM states:
  - IDLE: if tick && sweep_en -> RD.
  - RD: hold <= file[sweep_idx] + STEP (mod 2**DATA_W) -> WR.
  - WR, normal case: if !wr_en, write hold to file[sweep_idx], sweep_idx++ (wraps DEPTH-1 -> 0), -> IDLE.
  - WR, collision: if wr_en && wr_addr==sweep_idx, external data is written, the sweep write is dropped, sweep_idx++, -> IDLE.
  - WR, stall: if wr_en && wr_addr!=sweep_idx, external write proceeds and the FSM stays in WR (retries next cycle).
  - RD-cycle external write to sweep_idx: RMW is marked stale and its write is dropped in WR; the external value is kept; sweep_idx still advances.
- Write arbitration: external writes always take the single write port, in every state.
- sweep_done: registered; high for the cycle after the WR that advanced sweep_idx from DEPTH-1 to 0 (whether written or dropped).
- sweep_en low: ticks are ignored in IDLE. An RMW already in RD/WR completes. sweep_idx is retained; the sweep resumes there when re-enabled.
- Latency: tick at cycle T -> RD at T+1 -> WR at T+2 -> new value visible at T+3 (no stall).

Decomposition:
- Package regfile_sweep_pkg: state enum (IDLE, RD, WR), default DATA_W/ADDR_W/TICK_DIV constants, reset-pattern function init_entry(i).
- One sub-module: tick_gen (parametrised TICK_DIV prescaler, outputs tick).

Test Plan (TICK_DIV=4, DATA_W=16, ADDR_W=4 unless stated):
- Reset, sweep_en=0: read all 16 entries via port A -> entry i = {i,i,8'h00}; busy=0, idx=0.
- wr_en, addr 3, data 16'hBEEF, then rd_addr_b=3 -> 16'hBEEF the cycle after the edge; old 16'h3300 in the write cycle.
- sweep_en=1 for one tick: entry 0 goes 16'h0000 -> 16'h0001 at T+3; idx=1; busy high for exactly 2 cycles.
- Preload entry 0 = 16'hFFFF, sweep one step -> 16'h0000 (wrap, no side effects).
- External write to addr 0 during RD -> entry 0 holds external data, idx advances to 1. External write to addr 7 during WR -> FSM stalls one cycle, then entry 0 = old+1.
- Run 16 steps -> sweep_done pulses once, idx=0, every entry +1. Assert rst during WR of step 5 -> all entries back to reset pattern, no stray write after release.
